// File: rtl/fp32_pkg.sv
// Shared constants, round-mode encoding, flag-vector layout and result
// record for the binary32 add/sub path.
package fp32_pkg;

  localparam int BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [7:0] EXP_MAX_FINITE = 8'(2 * BIAS);
  localparam logic [22:0] QNAN_FRAC = 23'h400000;
  localparam logic [22:0] FRAC_ONES = 23'h7FFFFF;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RZ  = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } round_mode_e;

  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_INVALID   = 4;
  localparam int NUM_FLAGS      = 5;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter over a 24-bit significand; an all-zero input
// reports 24 so the caller can shift bits below the field into place.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);

  // Scan upward so the most significant set bit decides the final count.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_add_sub.sv
// Binary32 adder/subtractor: combinational align/add/normalize/round with
// special-case override, followed by one output register stage.
module fp32_add_sub
  import fp32_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Sx,
  input  logic [EW-1:0] Ex,
  input  logic [MW-1:0] Mx,
  input  logic          Sy,
  input  logic [EW-1:0] Ey,
  input  logic [MW-1:0] My,
  input  logic          sub,
  input  logic          EOP,
  input  logic [1:0]    roundMode,
  output logic          Sz,
  output logic [EW-1:0] Ez,
  output logic [MW-1:0] Mz_final,
  output logic          invalid_flag,
  output logic          overflow_flag,
  output logic          underflow_flag,
  output logic          inexact_flag,
  output logic          zero_flag
);

  round_mode_e rm;
  logic sy_eff, x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
  logic x_ge, sign_big;
  logic [7:0] ea, eb, diff;
  logic [23:0] ma, mb;
  logic [49:0] b_wide;
  logic [26:0] a_ext, b_ext;
  logic [27:0] sum;
  logic [4:0] lzc;
  logic [26:0] norm;
  logic [23:0] m_pre;
  logic g, st, round_up, inexact;
  logic [24:0] m_rnd;
  logic [22:0] frac_rnd;
  logic signed [9:0] e_norm, e_fin;
  fp32_t res_n;
  logic [NUM_FLAGS-1:0] flags_n;

  assign rm     = round_mode_e'(roundMode);
  assign sy_eff = Sy ^ sub;
  assign x_zero = (Ex == 8'h00);
  assign y_zero = (Ey == 8'h00);
  assign x_inf  = (Ex == EXP_MAX) && (Mx == '0);
  assign y_inf  = (Ey == EXP_MAX) && (My == '0);
  assign x_nan  = (Ex == EXP_MAX) && (Mx != '0);
  assign y_nan  = (Ey == EXP_MAX) && (My != '0);

  // Operand A is always the larger magnitude, so subtraction never goes negative.
  assign x_ge     = {Ex, Mx} >= {Ey, My};
  assign sign_big = x_ge ? Sx : sy_eff;
  assign ea       = x_ge ? Ex : Ey;
  assign eb       = x_ge ? Ey : Ex;
  assign ma       = {1'b1, (x_ge ? Mx : My)};
  assign mb       = {1'b1, (x_ge ? My : Mx)};
  assign diff     = ea - eb;

  // B carries guard and round bits, plus a sticky LSB that ORs everything shifted past them.
  assign b_wide = {mb, 26'b0} >> diff;
  assign b_ext  = (diff >= 8'd26) ? {26'b0, 1'b1} : {b_wide[49:24], |b_wide[23:0]};
  assign a_ext  = {ma, 3'b000};
  assign sum    = EOP ? ({1'b0, a_ext} - {1'b0, b_ext}) : ({1'b0, a_ext} + {1'b0, b_ext});

  fp_lzc24 u_lzc (
    .din   (sum[26:3]),
    .count (lzc)
  );

  always_comb begin
    norm = sum[26:0] << lzc;
    if (sum[27]) begin
      m_pre  = sum[27:4];
      g      = sum[3];
      st     = |sum[2:0];
      e_norm = $signed({2'b00, ea}) + 10'sd1;
    end else begin
      m_pre  = norm[26:3];
      g      = norm[2];
      st     = |norm[1:0];
      e_norm = $signed({2'b00, ea}) - $signed({5'b00000, lzc});
    end

    inexact = g | st;
    case (rm)
      RNE:     round_up = g & (st | m_pre[0]);
      RZ:      round_up = 1'b0;
      RUP:     round_up = inexact & ~sign_big;
      default: round_up = inexact & sign_big;
    endcase

    // A rounding carry leaves 1.000..0, so the fraction is zero and the exponent bumps.
    m_rnd = {1'b0, m_pre} + {24'b0, round_up};
    if (m_rnd[24]) begin
      frac_rnd = m_rnd[23:1];
      e_fin    = e_norm + 10'sd1;
    end else begin
      frac_rnd = m_rnd[22:0];
      e_fin    = e_norm;
    end
  end

  // Specials take precedence, then zero operands, then finite result classification.
  always_comb begin
    res_n                 = {sign_big, e_fin[7:0], frac_rnd};
    flags_n               = '0;
    flags_n[FLAG_INEXACT] = inexact;
    if (x_nan) begin
      res_n                 = {Sx, EXP_MAX, Mx | QNAN_FRAC};
      flags_n               = '0;
      flags_n[FLAG_INVALID] = 1'b1;
    end else if (y_nan) begin
      res_n                 = {Sy, EXP_MAX, My | QNAN_FRAC};
      flags_n               = '0;
      flags_n[FLAG_INVALID] = 1'b1;
    end else if (x_inf && y_inf && EOP) begin
      res_n                 = {1'b1, EXP_MAX, QNAN_FRAC};
      flags_n               = '0;
      flags_n[FLAG_INVALID] = 1'b1;
    end else if (x_inf) begin
      res_n   = {Sx, EXP_MAX, 23'h0};
      flags_n = '0;
    end else if (y_inf) begin
      res_n   = {sy_eff, EXP_MAX, 23'h0};
      flags_n = '0;
    end else if (x_zero && y_zero) begin
      res_n              = {((Sx == sy_eff) ? Sx : (rm == RDN)), 8'h00, 23'h0};
      flags_n            = '0;
      flags_n[FLAG_ZERO] = 1'b1;
    end else if (x_zero) begin
      res_n   = {sy_eff, Ey, My};
      flags_n = '0;
    end else if (y_zero) begin
      res_n   = {Sx, Ex, Mx};
      flags_n = '0;
    end else if (sum == '0) begin
      res_n              = {(rm == RDN), 8'h00, 23'h0};
      flags_n            = '0;
      flags_n[FLAG_ZERO] = 1'b1;
    end else if (e_norm <= 10'sd0) begin
      res_n                   = {sign_big, 8'h00, 23'h0};
      flags_n                 = '0;
      flags_n[FLAG_UNDERFLOW] = 1'b1;
      flags_n[FLAG_ZERO]      = 1'b1;
    end else if (e_fin >= 10'sd255) begin
      flags_n                = '0;
      flags_n[FLAG_OVERFLOW] = 1'b1;
      if (rm == RNE || (rm == RUP && !sign_big) || (rm == RDN && sign_big))
        res_n = {sign_big, EXP_MAX, 23'h0};
      else
        res_n = {sign_big, EXP_MAX_FINITE, FRAC_ONES};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sz             <= 1'b0;
      Ez             <= '0;
      Mz_final       <= '0;
      invalid_flag   <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      inexact_flag   <= 1'b0;
      zero_flag      <= 1'b0;
    end else begin
      Sz             <= res_n.sign;
      Ez             <= res_n.exp;
      Mz_final       <= res_n.frac;
      invalid_flag   <= flags_n[FLAG_INVALID];
      overflow_flag  <= flags_n[FLAG_OVERFLOW];
      underflow_flag <= flags_n[FLAG_UNDERFLOW];
      inexact_flag   <= flags_n[FLAG_INEXACT];
      zero_flag      <= flags_n[FLAG_ZERO];
    end
  end

endmodule

// File: tb/tb_fp32_add_sub.sv
// Directed plus randomized bench for fp32_add_sub; random results are
// judged against an exact wide-integer sum rounded by the bench itself.
module tb_fp32_add_sub;

  logic clk, rst;
  logic Sx, Sy, sub, EOP;
  logic [7:0] Ex, Ey;
  logic [22:0] Mx, My;
  logic [1:0] roundMode;
  logic Sz;
  logic [7:0] Ez;
  logic [22:0] Mz_final;
  logic invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag;

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  fp32_add_sub dut (
    .clk            (clk),
    .rst            (rst),
    .Sx             (Sx),
    .Ex             (Ex),
    .Mx             (Mx),
    .Sy             (Sy),
    .Ey             (Ey),
    .My             (My),
    .sub            (sub),
    .EOP            (EOP),
    .roundMode      (roundMode),
    .Sz             (Sz),
    .Ez             (Ez),
    .Mz_final       (Mz_final),
    .invalid_flag   (invalid_flag),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .inexact_flag   (inexact_flag),
    .zero_flag      (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one operation, let one edge capture it, then settle past the edge.
  task automatic applyStimulus(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                               input logic sy, input logic [7:0] ey, input logic [22:0] my,
                               input logic op, input logic [1:0] rm);
    Sx = sx; Ex = ex; Mx = mx;
    Sy = sy; Ey = ey; My = my;
    sub = op; EOP = sx ^ sy ^ op; roundMode = rm;
    @(posedge clk);
    #1;
    vectors++;
  endtask

  // Flags are compared as {invalid, overflow, underflow, inexact, zero}.
  task automatic checkOutput(input string tag, input logic esz, input logic [7:0] eez,
                             input logic [22:0] emz, input logic [4:0] efl);
    logic [4:0] fl;
    fl = {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};
    checks++;
    assert (Sz === esz) else begin
      miscompares++;
      $error("[TB] FAIL %s sign observed=%0b expected=%0b", tag, Sz, esz);
    end
    checks++;
    assert (Ez === eez) else begin
      miscompares++;
      $error("[TB] FAIL %s exp observed=%h expected=%h", tag, Ez, eez);
    end
    checks++;
    assert (Mz_final === emz) else begin
      miscompares++;
      $error("[TB] FAIL %s frac observed=%h expected=%h", tag, Mz_final, emz);
    end
    checks++;
    assert (fl === efl) else begin
      miscompares++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", tag, fl, efl);
    end
  endtask

  // Exact value: significands scaled to the smaller exponent, summed as wide integers, then rounded.
  function automatic void refModel(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                   input logic sy, input logic [7:0] ey, input logic [22:0] my,
                                   input logic op, input logic [1:0] rm,
                                   output logic sz, output logic [7:0] ez,
                                   output logic [22:0] mz, output logic [4:0] fl);
    logic sye, sgn, up;
    logic [299:0] a, b, mag, rem, half, keep;
    int p, e, emin;
    sye = sy ^ op;
    sz = 1'b0; ez = 8'h00; mz = 23'h0; fl = 5'b00000;
    if (ex == 8'hFF && mx != 0) begin sz = sx; ez = 8'hFF; mz = mx | 23'h400000; fl = 5'b10000; return; end
    if (ey == 8'hFF && my != 0) begin sz = sy; ez = 8'hFF; mz = my | 23'h400000; fl = 5'b10000; return; end
    if (ex == 8'hFF && ey == 8'hFF && sx != sye) begin sz = 1'b1; ez = 8'hFF; mz = 23'h400000; fl = 5'b10000; return; end
    if (ex == 8'hFF) begin sz = sx; ez = 8'hFF; return; end
    if (ey == 8'hFF) begin sz = sye; ez = 8'hFF; return; end
    if (ex == 0 && ey == 0) begin sz = (sx == sye) ? sx : (rm == 2'b11); fl = 5'b00001; return; end
    if (ex == 0) begin sz = sye; ez = ey; mz = my; return; end
    if (ey == 0) begin sz = sx; ez = ex; mz = mx; return; end
    emin = (ex < ey) ? int'(ex) : int'(ey);
    a = 300'({1'b1, mx}) << (int'(ex) - emin);
    b = 300'({1'b1, my}) << (int'(ey) - emin);
    if (sx == sye) begin mag = a + b; sgn = sx; end
    else if (a >= b) begin mag = a - b; sgn = sx; end
    else begin mag = b - a; sgn = sye; end
    if (mag == 0) begin sz = (rm == 2'b11); fl = 5'b00001; return; end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (e <= 0) begin sz = sgn; fl = 5'b00101; return; end
    if (p > 23) begin
      keep = mag >> (p - 23);
      rem  = mag & ((300'd1 << (p - 23)) - 300'd1);
      half = 300'd1 << (p - 24);
    end else begin
      keep = mag << (23 - p);
      rem  = '0;
      half = '0;
    end
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && rem != 0 && keep[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = (rem != 0) && !sgn;
      default: up = (rem != 0) && sgn;
    endcase
    if (up) keep = keep + 300'd1;
    if (keep[24]) begin keep = keep >> 1; e = e + 1; end
    sz = sgn;
    if (e >= 255) begin
      fl = 5'b01000;
      if (rm == 2'b00 || (rm == 2'b10 && !sgn) || (rm == 2'b11 && sgn)) begin ez = 8'hFF; mz = 23'h0; end
      else begin ez = 8'hFE; mz = 23'h7FFFFF; end
      return;
    end
    ez = 8'(e);
    mz = keep[22:0];
    fl = {3'b000, (rem != 0), 1'b0};
  endfunction

  function automatic void pickOperand(output logic [7:0] e, output logic [22:0] m);
    int k;
    k = $urandom_range(0, 19);
    m = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) begin e = 8'hFF; m = 23'h0; end
    else if (k == 2) begin e = 8'hFF; if (m == 0) m = 23'h1; end
    else if (k < 5) e = 8'($urandom_range(240, 254));
    else if (k < 7) e = 8'($urandom_range(1, 8));
    else e = 8'($urandom_range(1, 254));
  endfunction

  initial begin
    logic rsx, rsy, rop, esz;
    logic [7:0] rex, rey, eez;
    logic [22:0] rmx, rmy, emz;
    logic [4:0] efl;
    logic [1:0] rrm;

    rst = 1'b1;
    Sx = 0; Ex = 0; Mx = 0; Sy = 0; Ey = 0; My = 0; sub = 0; EOP = 0; roundMode = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 8'h00, 23'h0, 5'b00000);
    rst = 1'b0;

    applyStimulus(0, 8'h81, 23'h700000, 0, 8'h80, 23'h100000, 0, 2'b00);
    checkOutput("add", 0, 8'h82, 23'h1C0000, 5'b00000);
    applyStimulus(0, 8'h80, 23'h400001, 0, 8'h81, 23'h400000, 0, 2'b00);
    checkOutput("inexact", 0, 8'h82, 23'h100000, 5'b00010);
    applyStimulus(0, 8'h81, 23'h700000, 0, 8'h80, 23'h100000, 1, 2'b00);
    checkOutput("sub", 0, 8'h81, 23'h280000, 5'b00000);
    applyStimulus(0, 8'h80, 23'h100000, 0, 8'h81, 23'h700000, 1, 2'b00);
    checkOutput("sub_swap", 1, 8'h81, 23'h280000, 5'b00000);
    applyStimulus(0, 8'h81, 23'h700100, 0, 8'h81, 23'h700000, 1, 2'b00);
    checkOutput("cancel", 0, 8'h72, 23'h0, 5'b00000);
    applyStimulus(0, 8'h81, 23'h100000, 0, 8'h81, 23'h700000, 1, 2'b00);
    checkOutput("cancel_neg", 1, 8'h80, 23'h400000, 5'b00000);
    applyStimulus(0, 8'hFE, 23'h7FFFFF, 0, 8'hFE, 23'h7FFFFF, 0, 2'b00);
    checkOutput("ovf_rne", 0, 8'hFF, 23'h0, 5'b01000);
    applyStimulus(0, 8'hFE, 23'h7FFFFF, 0, 8'hFE, 23'h7FFFFF, 0, 2'b01);
    checkOutput("ovf_rz", 0, 8'hFE, 23'h7FFFFF, 5'b01000);
    applyStimulus(1, 8'hFE, 23'h7FFFFF, 1, 8'hFE, 23'h7FFFFF, 0, 2'b10);
    checkOutput("ovf_rup_neg", 1, 8'hFE, 23'h7FFFFF, 5'b01000);
    applyStimulus(0, 8'hFF, 23'h000208, 0, 8'h80, 23'h100000, 0, 2'b00);
    checkOutput("nan", 0, 8'hFF, 23'h400208, 5'b10000);
    applyStimulus(0, 8'hFF, 23'h0, 0, 8'hFF, 23'h0, 1, 2'b00);
    checkOutput("inf_minus_inf", 1, 8'hFF, 23'h400000, 5'b10000);
    applyStimulus(1, 8'hFF, 23'h0, 0, 8'h90, 23'h123456, 0, 2'b00);
    checkOutput("inf_plus_fin", 1, 8'hFF, 23'h0, 5'b00000);
    applyStimulus(0, 8'h81, 23'h700000, 0, 8'h81, 23'h700000, 1, 2'b00);
    checkOutput("equal_sub", 0, 8'h00, 23'h0, 5'b00001);
    applyStimulus(0, 8'h81, 23'h700000, 0, 8'h81, 23'h700000, 1, 2'b11);
    checkOutput("equal_sub_rdn", 1, 8'h00, 23'h0, 5'b00001);
    applyStimulus(1, 8'h00, 23'h0, 0, 8'h00, 23'h0, 1, 2'b00);
    checkOutput("zero_same_sign", 1, 8'h00, 23'h0, 5'b00001);
    applyStimulus(0, 8'h00, 23'h000123, 0, 8'h85, 23'h0, 0, 2'b00);
    checkOutput("denorm_flush", 0, 8'h85, 23'h0, 5'b00000);
    applyStimulus(0, 8'h01, 23'h000001, 0, 8'h01, 23'h0, 1, 2'b00);
    checkOutput("underflow", 0, 8'h00, 23'h0, 5'b00101);
    applyStimulus(0, 8'h90, 23'h0, 0, 8'h70, 23'h000001, 0, 2'b10);
    checkOutput("far_sticky_rup", 0, 8'h90, 23'h000001, 5'b00010);

    rst = 1'b1;
    applyStimulus(0, 8'h81, 23'h700000, 0, 8'h80, 23'h100000, 0, 2'b00);
    checkOutput("reset_in_flight", 0, 8'h00, 23'h0, 5'b00000);
    rst = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      pickOperand(rex, rmx);
      pickOperand(rey, rmy);
      if ($urandom_range(0, 2) == 0 && rex != 8'h00 && rex != 8'hFF) begin
        rey = rex;
        rmy = rmx ^ 23'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1 && rex > 8'h01) rey = rex - 8'd1;
      end
      if ($urandom_range(0, 9) == 0) begin rey = rex; rmy = rmx; end
      rsx = 1'($urandom);
      rsy = 1'($urandom);
      rop = 1'($urandom);
      rrm = 2'($urandom);
      refModel(rsx, rex, rmx, rsy, rey, rmy, rop, rrm, esz, eez, emz, efl);
      applyStimulus(rsx, rex, rmx, rsy, rey, rmy, rop, rrm);
      checkOutput($sformatf("rand%0d", i), esz, eez, emz, efl);
    end

    $display("[TB] %0d comparisons made", checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
